// File: rtl/airi5c_rshift_sequencer.sv
// Iterative right shifter with sticky tracking: one power-of-two stage per clock,
// largest stage first, every discarded bit ORed into the sticky flag.
module airi5c_rshift_sequencer #(
  parameter int n  = 32,
  parameter int aw = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          kill,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [n-1:0]  in_data,
  input  logic [aw-1:0] in_amt,
  input  logic          in_sgn,
  input  logic          in_sticky,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [n-1:0]  out_data,
  output logic          out_sticky,
  output logic          busy
);

  localparam int k  = $clog2(n);
  localparam int cw = $clog2(k);
  localparam logic [cw-1:0] last_stage = cw'(k - 1);
  localparam logic [aw-1:0] sat_amt    = aw'(n);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state_q, state_d;
  logic [n-1:0]  data_q;
  logic [k-1:0]  amt_q;
  logic          sgn_q;
  logic          sticky_q;
  logic [cw-1:0] cnt_q;

  logic          amt_zero, amt_sat, stage_en;
  logic [n-1:0]  stage_data;
  logic          stage_sticky;

  assign amt_zero = (in_amt == '0);
  assign amt_sat  = (in_amt >= sat_amt);
  assign stage_en = amt_q[cnt_q];

  // Each stage is a fixed shift; the counter only selects which one applies.
  always_comb begin
    stage_data   = data_q;
    stage_sticky = sticky_q;
    for (int unsigned s = 0; s < k; s++) begin
      if (stage_en && (cnt_q == cw'(s))) begin
        stage_data   = n'({{n{sgn_q}}, data_q} >> (2 ** s));
        stage_sticky = sticky_q | (|(data_q & ~({n{1'b1}} << (2 ** s))));
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = (amt_zero || amt_sat) ? DONE : SHIFT;
      SHIFT:   if (cnt_q == '0) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Reset and kill have identical effects, so one branch serves both.
  always_ff @(posedge clk) begin
    if (reset || kill) begin
      state_q  <= IDLE;
      data_q   <= '0;
      amt_q    <= '0;
      sgn_q    <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= last_stage;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            cnt_q <= last_stage;
            if (amt_zero) begin
              data_q   <= in_data;
              sticky_q <= in_sticky;
            end else if (amt_sat) begin
              data_q   <= {n{in_sgn}};
              sticky_q <= in_sticky | (|in_data);
            end else begin
              data_q   <= in_data;
              amt_q    <= in_amt[k-1:0];
              sgn_q    <= in_sgn;
              sticky_q <= in_sticky;
            end
          end
        end
        SHIFT: begin
          data_q   <= stage_data;
          sticky_q <= stage_sticky;
          if (cnt_q != '0) cnt_q <= cnt_q - cw'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign out_data   = data_q;
  assign out_sticky = sticky_q;

endmodule

// File: doc/airi5c_rshift_sequencer.md
Name: airi5c_rshift_sequencer

Overview:
- Iterative, sticky-tracking right-shift engine for FPU mantissa alignment and denormalisation.
- Decomposes a variable shift amount into power-of-two static right-shift stages. Applies one stage per clock, MSB of the amount first, and ORs every discarded bit into a sticky flag.
- Sits between the FPU operand-unpack stage and the adder/converter datapath.
- Trades log2(n) cycles of latency for the area of a full barrel shifter.
- Valid/ready on both sides.

Parameters:
- n, 32: data width. Must be a power of two, at least 4.
- aw, 6: shift-amount width. Must satisfy 2^aw > n.
- localparam k = log2(n): number of shift stages. Stage s shifts by 2^s.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- kill  in  1  synchronous flush of any in-flight operation.
- in_valid  in  1  request valid.
- in_ready  out  1  high only in IDLE.
- in_data  in  n  operand.
- in_amt  in  aw  right-shift amount (unsigned).
- in_sgn  in  1  fill bit shifted in at the MSB (1 = arithmetic).
- in_sticky  in  1  sticky carried in from upstream.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  n  shifted result.
- out_sticky  out  1  in_sticky OR all discarded bits.
- busy  out  1  state != IDLE.

Behaviour:
- Reset values (reset high at an edge): state = IDLE, in_ready = 1, out_valid = 0, out_data = 0, out_sticky = 0, busy = 0, stage counter = k-1.
- Priority: reset > kill > normal operation.
- States: IDLE, SHIFT, DONE.
- IDLE: in_ready = 1. On in_valid, the edge is the accept edge.
  - Fast path, in_amt == 0: out_data = in_data, out_sticky = in_sticky, state goes to DONE.
  - Fast path, in_amt >= n: out_data = {n{in_sgn}}, out_sticky = in_sticky | (|in_data), state goes to DONE.
  - Otherwise: load data reg = in_data, amt reg, sgn reg, sticky reg = in_sticky, stage counter = k-1; state goes to SHIFT.
- SHIFT: each edge processes stage s = counter.
  - If amt[s] = 1: data = {2^s x sgn, data[n-1:2^s]} and sticky |= |data[2^s-1:0].
  - If amt[s] = 0: data and sticky are unchanged.
  - If s == 0, state goes to DONE; else counter decrements.
  - Stages are processed in a fixed order, never skipped (constant latency).
- DONE: out_valid = 1. out_data and out_sticky stay stable while out_ready = 0.
  - On out_ready, state goes to IDLE.
  - There is no same-cycle accept: in_ready stays 0 in DONE.
- Latency, counted from the accept edge to the edge after which out_valid = 1:
  - Fast path: 1 edge.
  - Normal path: k+1 edges (k = 5 for n = 32).
- Throughput: at most one operation per k+2 cycles on the normal path, per 2 cycles on the fast path.
- kill in any state: next edge goes to IDLE with out_valid = 0 and out_data/out_sticky = 0. No result is produced. in_valid in the same cycle as kill is ignored.
- Reset mid-operation: identical to kill; all outputs take reset values.
- in_data, in_amt, in_sgn and in_sticky are sampled only at the accept edge. Later changes have no effect.
- Width rule: in_amt bits at or above position k matter only in the saturation compare (in_amt >= n). The normal path uses in_amt[k-1:0].
- No X propagation: out_data is registered and driven from reset.

Test Plan (n = 32, aw = 6):
1. Simple shift: in_data = 0x8000_0001, in_amt = 1, in_sgn = 0, in_sticky = 0 -> out_data = 0x4000_0000, out_sticky = 1. out_valid rises 6 edges after accept.
2. Multi-stage shift, exact: in_data = 0x1234_5000, in_amt = 12, in_sgn = 0 -> out_data = 0x0001_2345, out_sticky = 0 (only stages 3 and 2 active). Arithmetic: in_data = 0x8000_0000, in_amt = 4, in_sgn = 1 -> out_data = 0xF800_0000, out_sticky = 0.
3. Fast paths:
   - in_amt = 40, in_data = 0x0000_0001, in_sgn = 0 -> out_data = 0, out_sticky = 1, out_valid 1 edge after accept.
   - in_amt = 0, in_data = 0xDEAD_BEEF, in_sticky = 1 -> out_data = 0xDEAD_BEEF, out_sticky = 1, 1 edge.
4. Backpressure: hold out_ready = 0 for 3 cycles in DONE -> out_data/out_sticky stable, in_ready = 0, busy = 1. Assert out_ready -> IDLE next edge, in_ready = 1. A back-to-back second request is accepted only then.
5. Kill/reset mid-op: assert kill on the 3rd SHIFT cycle -> IDLE next edge, out_valid never rises, outputs = 0. Repeat with reset high instead of kill -> all outputs at reset values, next request processed correctly.
6. Random regression: 10k random (in_data, in_amt in 0..63, in_sgn, in_sticky) with random out_ready stalls -> result matches a golden model of arithmetic shift plus OR-of-discarded-bits, with exact latency checked.
